// File: rtl/uart_rx_match.sv
// 8N1 UART receiver feeding a matcher for the 15-byte ID string "hitsz2024311259".
// Define UART_RX_SYNC_EN to pass rx through a two-flop synchronizer (adds 2 cycles of latency).
module uart_rx_match #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [3:0] char_index,
  output logic       match
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = $clog2(BIT_CYC + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
  localparam logic [3:0]       LAST_IDX  = 4'd14;
  localparam logic [7:0]       FIRST_CHR = 8'h68;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  function automatic logic [7:0] expected_char(input logic [3:0] idx);
    case (idx)
      4'd0:    expected_char = 8'h68;
      4'd1:    expected_char = 8'h69;
      4'd2:    expected_char = 8'h74;
      4'd3:    expected_char = 8'h73;
      4'd4:    expected_char = 8'h7A;
      4'd5:    expected_char = 8'h32;
      4'd6:    expected_char = 8'h30;
      4'd7:    expected_char = 8'h32;
      4'd8:    expected_char = 8'h34;
      4'd9:    expected_char = 8'h33;
      4'd10:   expected_char = 8'h31;
      4'd11:   expected_char = 8'h31;
      4'd12:   expected_char = 8'h32;
      4'd13:   expected_char = 8'h35;
      4'd14:   expected_char = 8'h39;
      default: expected_char = 8'h00;
    endcase
  endfunction

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // NOTE: synchronizer flops reset to the idle line level (1) so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             armed_q;
  logic             cnt_clr;
  logic             shift_en;
  logic             stop_ok;
  logic             stop_bad;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      IDLE: begin
        // armed_q blocks a start on a line that was already low when reset released
        if (armed_q && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_en = 1'b1;
          cnt_clr  = 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          stop_ok  = rx_s;
          stop_bad = !rx_s;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
    end else begin
      if (state_q == IDLE || state_d != state_q || cnt_clr) cnt_q <= '0;
      else                                                  cnt_q <= cnt_q + 1'b1;
      if (shift_en) begin
        bit_q   <= bit_q + 1'b1;
        shift_q <= {rx_s, shift_q[7:1]};
      end
      if (rx_s) armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= stop_ok;
      frame_err <= stop_bad;
      if (stop_ok) rx_data <= shift_q;
    end
  end

  // Matcher runs one cycle behind the receiver and never stalls it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_index <= 4'd0;
      match      <= 1'b0;
    end else begin
      match <= 1'b0;
      if (rx_valid) begin
        if (rx_data == expected_char(char_index)) begin
          if (char_index == LAST_IDX) begin
            char_index <= 4'd0;
            match      <= 1'b1;
          end else begin
            char_index <= char_index + 4'd1;
          end
        end else begin
          char_index <= (rx_data == FIRST_CHR) ? 4'd1 : 4'd0;
        end
      end else if (frame_err) begin
        char_index <= 4'd0;
      end
    end
  end

endmodule
